// File: rtl/clock_alarm_pkg.sv
// Shared types and constants for the alarm clock controller.
// Holds field widths, the alarm state encoding and a time-range check.
package clock_alarm_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned RCNT_W = 8;
    localparam int unsigned SNZ_W  = 2;

    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned MIN_PER_HOUR  = 60;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    // True when hours:minutes is a legal time of day.
    function automatic logic time_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
        return (h < HOUR_W'(HOURS_PER_DAY)) && (m < MIN_W'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/clock_alarm_time_add.sv
// Combinational hours:minutes plus a minute offset (offset <= 59),
// wrapping minutes at 60 with carry into hours and hours at 24.
module alarm_time_add
    import clock_alarm_pkg::*;
(
    input  logic [HOUR_W-1:0] hours,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [MIN_W-1:0]  offset,
    output logic [HOUR_W-1:0] sum_hours_c,
    output logic [MIN_W-1:0]  sum_minutes_c
);

    localparam int unsigned MSUM_W = MIN_W + 1;
    localparam int unsigned HSUM_W = HOUR_W + 1;

    logic [MSUM_W-1:0] min_sum;
    logic [HSUM_W-1:0] hour_sum;
    logic              carry;

    always_comb begin
        min_sum = {1'b0, minutes} + {1'b0, offset};
        carry   = 1'b0;
        if (min_sum >= MSUM_W'(MIN_PER_HOUR)) begin
            min_sum = min_sum - MSUM_W'(MIN_PER_HOUR);
            carry   = 1'b1;
        end
        hour_sum = {1'b0, hours} + HSUM_W'(carry);
        if (hour_sum >= HSUM_W'(HOURS_PER_DAY)) begin
            hour_sum = hour_sum - HSUM_W'(HOURS_PER_DAY);
        end
        sum_minutes_c = min_sum[MIN_W-1:0];
        sum_hours_c   = hour_sum[HOUR_W-1:0];
    end

endmodule

// File: rtl/clock_alarm.sv
// Alarm controller: stores an alarm time, rings on the matching minute,
// supports limited snoozes, stop, disarm and an auto-stop ring timeout.
module clock_alarm
    import clock_alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEC_W-1:0]  seconds,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [HOUR_W-1:0] hours,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic              arm,
    input  logic              disarm,
    input  logic              snooze,
    input  logic              stop,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic              armed,
    output logic              ringing,
    output logic              buzzer,
    output logic [SNZ_W-1:0]  snooze_left,
    output logic              missed
);

    state_t            state;
    state_t            state_next;
    logic [SEC_W-1:0]  prev_sec;
    logic [HOUR_W-1:0] wake_hours;
    logic [MIN_W-1:0]  wake_minutes;
    logic [RCNT_W-1:0] ring_cnt;

    logic              tick_c;
    logic              trigger_c;
    logic              set_ok_c;
    logic [HOUR_W-1:0] target_hours;
    logic [MIN_W-1:0]  target_minutes;
    logic [HOUR_W-1:0] add_hours;
    logic [MIN_W-1:0]  add_minutes;

    logic              arm_take;
    logic              stop_take;
    logic              snooze_take;
    logic              timeout_take;
    logic              trig_take;

    logic              armed_d;
    logic              ringing_d;
    logic              buzzer_d;

    alarm_time_add u_wake_add (
        .hours         (hours),
        .minutes       (minutes),
        .offset        (MIN_W'(SNOOZE_MIN)),
        .sum_hours_c   (add_hours),
        .sum_minutes_c (add_minutes)
    );

    // Any change of the seconds value, including a backwards jump, is one tick.
    assign tick_c = (seconds != prev_sec);

    always_comb begin
        target_hours   = alarm_hours;
        target_minutes = alarm_minutes;
        if (state == ST_SNOOZE) begin
            target_hours   = wake_hours;
            target_minutes = wake_minutes;
        end
    end

    assign trigger_c = tick_c && (seconds == '0) &&
                       (hours == target_hours) && (minutes == target_minutes);

    assign set_ok_c = ((state == ST_DISARMED) || (state == ST_ARMED)) &&
                      time_valid(set_hours, set_minutes);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_DISARMED;
        end else begin
            state <= state_next;
        end
    end

    // Next state; disarm wins over everything, then stop, snooze, timeout, trigger.
    always_comb begin
        state_next   = state;
        arm_take     = 1'b0;
        stop_take    = 1'b0;
        snooze_take  = 1'b0;
        timeout_take = 1'b0;
        trig_take    = 1'b0;
        if (disarm) begin
            state_next = ST_DISARMED;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (arm) begin
                        state_next = ST_ARMED;
                        arm_take   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trigger_c) begin
                        state_next = ST_RINGING;
                        trig_take  = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        state_next = ST_ARMED;
                        stop_take  = 1'b1;
                    end else if (snooze && (snooze_left != '0)) begin
                        state_next  = ST_SNOOZE;
                        snooze_take = 1'b1;
                    end else if (tick_c && (ring_cnt == RCNT_W'(RING_SEC - 1))) begin
                        state_next   = ST_ARMED;
                        timeout_take = 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_next = ST_ARMED;
                        stop_take  = 1'b1;
                    end else if (trigger_c) begin
                        state_next = ST_RINGING;
                        trig_take  = 1'b1;
                    end
                end
                default: state_next = ST_DISARMED;
            endcase
        end
    end

    // Output decode from the upcoming state so outputs change one cycle after the cause.
    always_comb begin
        armed_d   = 1'b0;
        ringing_d = 1'b0;
        buzzer_d  = 1'b0;
        case (state_next)
            ST_ARMED, ST_SNOOZE: armed_d = 1'b1;
            ST_RINGING: begin
                armed_d   = 1'b1;
                ringing_d = 1'b1;
                buzzer_d  = ~seconds[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
        end else begin
            armed   <= armed_d;
            ringing <= ringing_d;
            buzzer  <= buzzer_d;
        end
    end

    // Alarm time, wake time, ring counter, snooze budget and missed flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            wake_hours    <= '0;
            wake_minutes  <= '0;
            prev_sec      <= '0;
            ring_cnt      <= '0;
            snooze_left   <= SNZ_W'(MAX_SNOOZE);
            missed        <= 1'b0;
        end else begin
            prev_sec <= seconds;

            if (set_en && set_ok_c) begin
                alarm_hours   <= set_hours;
                alarm_minutes <= set_minutes;
            end

            if (trig_take) begin
                ring_cnt <= '0;
            end else if ((state == ST_RINGING) && tick_c) begin
                ring_cnt <= ring_cnt + RCNT_W'(1);
            end

            if (snooze_take) begin
                wake_hours   <= add_hours;
                wake_minutes <= add_minutes;
                snooze_left  <= snooze_left - SNZ_W'(1);
            end else if (arm_take || stop_take || timeout_take) begin
                snooze_left <= SNZ_W'(MAX_SNOOZE);
            end

            if (timeout_take) begin
                missed <= 1'b1;
            end else if (arm_take || (stop && !disarm)) begin
                missed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_alarm.sv
// Scoreboard bench for clock_alarm: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_clock_alarm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [4:0] hours = '0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       armed;
    logic       ringing;
    logic       buzzer;
    logic [1:0] snooze_left;
    logic       missed;

    typedef struct packed {
        int unsigned cyc;
        int unsigned id;
        logic        armed;
        logic        ringing;
        logic        buzzer;
        logic [1:0]  sl;
        logic        missed;
        logic [4:0]  ah;
        logic [5:0]  am;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    clock_alarm #(.SNOOZE_MIN(5), .RING_SEC(60), .MAX_SNOOZE(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .seconds       (seconds),
        .minutes       (minutes),
        .hours         (hours),
        .set_en        (set_en),
        .set_hours     (set_hours),
        .set_minutes   (set_minutes),
        .arm           (arm),
        .disarm        (disarm),
        .snooze        (snooze),
        .stop          (stop),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .armed         (armed),
        .ringing       (ringing),
        .buzzer        (buzzer),
        .snooze_left   (snooze_left),
        .missed        (missed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that targets the edge just completed.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.cyc != cyc || armed !== mon_e.armed || ringing !== mon_e.ringing ||
                buzzer !== mon_e.buzzer || snooze_left !== mon_e.sl || missed !== mon_e.missed ||
                alarm_hours !== mon_e.ah || alarm_minutes !== mon_e.am) begin
                errors++;
                $display("FAIL chk%0d: got armed=%b ringing=%b buzzer=%b snooze_left=%0d missed=%b alarm=%0d:%0d, want armed=%b ringing=%b buzzer=%b snooze_left=%0d missed=%b alarm=%0d:%0d",
                         mon_e.id, armed, ringing, buzzer, snooze_left, missed, alarm_hours, alarm_minutes,
                         mon_e.armed, mon_e.ringing, mon_e.buzzer, mon_e.sl, mon_e.missed, mon_e.ah, mon_e.am);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        set_en = 1'b0;
        arm    = 1'b0;
        disarm = 1'b0;
        snooze = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic set_t(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    task automatic chk(input int unsigned id, input int a, input int r, input int b,
                       input int sl, input int ms, input int ah, input int am);
        exp_t e;
        e.cyc     = cyc;
        e.id      = id;
        e.armed   = 1'(a);
        e.ringing = 1'(r);
        e.buzzer  = 1'(b);
        e.sl      = 2'(sl);
        e.missed  = 1'(ms);
        e.ah      = 5'(ah);
        e.am      = 6'(am);
        q.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        set_t(0, 0, 0);
        step();
        step();
        chk(1, 0, 0, 0, 3, 0, 0, 0);
        rst = 1'b0;
        step();
        chk(2, 0, 0, 0, 3, 0, 0, 0);

        // Set 07:30, arm, ring at 07:30:00
        set_en = 1'b1; set_hours = 5'd7; set_minutes = 6'd30;
        step();
        chk(3, 0, 0, 0, 3, 0, 7, 30);
        arm = 1'b1;
        step();
        chk(4, 1, 0, 0, 3, 0, 7, 30);
        set_t(7, 29, 59); step();
        chk(5, 1, 0, 0, 3, 0, 7, 30);
        set_t(7, 30, 0); step();
        chk(6, 1, 1, 1, 3, 0, 7, 30);
        set_t(7, 30, 1); step();
        chk(7, 1, 1, 0, 3, 0, 7, 30);
        set_t(7, 30, 0); step();
        chk(8, 1, 1, 1, 3, 0, 7, 30);

        // Stop, then hold 07:30:00 with no retrigger
        stop = 1'b1;
        step();
        chk(9, 1, 0, 0, 3, 0, 7, 30);
        repeat (1000) step();
        chk(10, 1, 0, 0, 3, 0, 7, 30);

        // Invalid set requests are ignored, valid one accepted in ARMED
        set_en = 1'b1; set_hours = 5'd7; set_minutes = 6'd60;
        step();
        chk(11, 1, 0, 0, 3, 0, 7, 30);
        set_en = 1'b1; set_hours = 5'd24; set_minutes = 6'd0;
        step();
        chk(12, 1, 0, 0, 3, 0, 7, 30);
        set_en = 1'b1; set_hours = 5'd23; set_minutes = 6'd58;
        step();
        chk(13, 1, 0, 0, 3, 0, 23, 58);

        // Ring at 23:58, snooze wraps wake time to 00:03
        set_t(23, 57, 59); step();
        set_t(23, 58, 0); step();
        chk(14, 1, 1, 1, 3, 0, 23, 58);
        snooze = 1'b1;
        step();
        chk(15, 1, 0, 0, 2, 0, 23, 58);
        set_t(0, 2, 59); step();
        chk(16, 1, 0, 0, 2, 0, 23, 58);
        set_t(0, 3, 0); step();
        chk(17, 1, 1, 1, 2, 0, 23, 58);
        snooze = 1'b1;
        step();
        chk(18, 1, 0, 0, 1, 0, 23, 58);
        set_t(0, 7, 59); step();
        set_t(0, 8, 0); step();
        chk(19, 1, 1, 1, 1, 0, 23, 58);
        snooze = 1'b1;
        step();
        chk(20, 1, 0, 0, 0, 0, 23, 58);
        set_t(0, 12, 59); step();
        set_t(0, 13, 0); step();
        chk(21, 1, 1, 1, 0, 0, 23, 58);

        // Fourth snooze is ignored
        snooze = 1'b1;
        step();
        chk(22, 1, 1, 1, 0, 0, 23, 58);

        // Ring timeout after 60 ticks
        for (int s = 1; s < 60; s++) begin
            set_t(0, 13, s);
            step();
        end
        chk(23, 1, 1, 0, 0, 0, 23, 58);
        set_t(0, 14, 0); step();
        chk(24, 1, 0, 0, 3, 1, 23, 58);

        // arm outside DISARMED leaves missed set; stop clears it
        arm = 1'b1;
        step();
        chk(25, 1, 0, 0, 3, 1, 23, 58);
        stop = 1'b1;
        step();
        chk(26, 1, 0, 0, 3, 0, 23, 58);
        disarm = 1'b1;
        step();
        chk(27, 0, 0, 0, 3, 0, 23, 58);
        arm = 1'b1;
        step();
        chk(28, 1, 0, 0, 3, 0, 23, 58);

        // disarm beats stop while ringing
        set_t(23, 57, 59); step();
        set_t(23, 58, 0); step();
        chk(29, 1, 1, 1, 3, 0, 23, 58);
        disarm = 1'b1; stop = 1'b1;
        step();
        chk(30, 0, 0, 0, 3, 0, 23, 58);

        // Backwards time jump then retrigger; reset mid-ring
        arm = 1'b1;
        step();
        chk(31, 1, 0, 0, 3, 0, 23, 58);
        set_t(23, 57, 59); step();
        set_t(23, 58, 0); step();
        chk(32, 1, 1, 1, 3, 0, 23, 58);
        rst = 1'b1;
        step();
        chk(33, 0, 0, 0, 3, 0, 0, 0);
        rst = 1'b0;
        step();
        chk(34, 0, 0, 0, 3, 0, 0, 0);

        step();
        step();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_alarm.md
CLOCK_ALARM -- requirements
Module: clock_alarm

Interface
REQ-001 Parameter SNOOZE_MIN, default 5: snooze length in minutes (1..59).
REQ-002 Parameter RING_SEC, default 60: auto-stop after this many ringing seconds (1..255).
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 seconds  input  6  current seconds from the clock counter (0..59).
REQ-007 minutes  input  6  current minutes (0..59).
REQ-008 hours  input  5  current hours (0..23).
REQ-009 set_en  input  1  one-cycle strobe; load set_hours/set_minutes as alarm time.
REQ-010 set_hours  input  5  requested alarm hour.
REQ-011 set_minutes  input  6  requested alarm minute.
REQ-012 arm  input  1  one-cycle strobe; enable alarm.
REQ-013 disarm  input  1  one-cycle strobe; disable alarm from any state.
REQ-014 snooze  input  1  one-cycle strobe; snooze while ringing.
REQ-015 stop  input  1  one-cycle strobe; silence while ringing, stay armed.
REQ-016 alarm_hours  output  5  stored alarm hour.
REQ-017 alarm_minutes  output  6  stored alarm minute.
REQ-018 armed  output  1  high in ARMED, RINGING, SNOOZE.
REQ-019 ringing  output  1  high in RINGING.
REQ-020 buzzer  output  1  ringing AND seconds[0]==0 (beeps on even seconds).
REQ-021 snooze_left  output  2  MAX_SNOOZE minus snoozes used this event.
REQ-022 missed  output  1  sticky; set on ring timeout, cleared by arm or stop.

Function
REQ-023 Second tick SHALL be detected as seconds != registered previous seconds; one tick per second change, independent of how many clk cycles the time is held.
REQ-024 Trigger SHALL fire on a tick where seconds==0 and hours:minutes equal the active target (alarm time in ARMED, wake time in SNOOZE).
REQ-025 FSM states: DISARMED, ARMED, RINGING, SNOOZE; registered outputs, one-cycle latency from strobe/trigger to output change.
REQ-026 DISARMED: arm -> ARMED; snooze_left reloaded to MAX_SNOOZE.
REQ-027 ARMED: trigger -> RINGING; ring counter cleared.
REQ-028 RINGING: stop -> ARMED; snooze with snooze_left>0 -> SNOOZE, wake = current hours:minutes + SNOOZE_MIN, snooze_left decremented; snooze with snooze_left==0 ignored; ring counter reaching RING_SEC ticks -> ARMED, missed set.
REQ-029 SNOOZE: trigger on wake time -> RINGING, ring counter cleared; stop -> ARMED.
REQ-030 Leaving RINGING/SNOOZE to ARMED SHALL reload snooze_left to MAX_SNOOZE.
REQ-031 Wake-time addition SHALL wrap minutes at 60 with carry into hours, hours at 24 (23:58 + 5 -> 00:03).
REQ-032 set_en accepted only in DISARMED or ARMED; ignored if set_hours>23 or set_minutes>59; state unchanged.
REQ-033 Same-cycle priority: disarm > stop > snooze > ring timeout > trigger; arm ignored unless DISARMED.
REQ-034 Time input jumping backwards (clock reset) SHALL count as a tick but triggers only via REQ-024.

Reset
REQ-035 On rst: state DISARMED, alarm_hours 0, alarm_minutes 0, wake 00:00, previous-seconds register 0, ring counter 0, snooze_left MAX_SNOOZE, missed 0, armed/ringing/buzzer 0.
REQ-036 rst mid-ring SHALL silence buzzer the cycle after rst is sampled.

Structure
REQ-037 Package clock_alarm_pkg holds the state enum, time field widths, and constants 24/60.
REQ-038 One sub-module alarm_time_add: combinational hours:minutes plus minute offset with wrap, per REQ-031.

Verification
REQ-039 Set 07:30, arm, drive 07:29:59 -> 07:30:00 -> ringing=1 next cycle, buzzer=1 at :00, 0 at :01.
REQ-040 Ringing at 23:58:00, snooze -> SNOOZE, snooze_left=2; drive 00:03:00 -> ringing again.
REQ-041 Ring 60 ticks without input -> ARMED, missed=1, buzzer=0; arm clears missed only from DISARMED, stop clears otherwise.
REQ-042 Three snoozes used, fourth snooze while ringing -> stays RINGING, snooze_left=0.
REQ-043 Hold 07:30:00 for 1000 clk cycles after stop -> no retrigger; set_en with set_minutes=60 -> alarm_minutes unchanged.
REQ-044 disarm and stop same cycle while ringing -> DISARMED; rst while ringing -> all outputs at reset values.
